// File: rtl/jcs_bus_sequencer.sv
// Bus sequencer: turns LOAD/MOVE/ALU commands into timed enable/set selector
// sequences (setup, set, hold per transfer) for the shared 8-bit datapath.
module jcs_bus_sequencer #(
    parameter int SET_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_src,
    input  logic [1:0] cmd_dst,
    input  logic [2:0] cmd_alu,
    output logic [3:0] ena_sel,
    output logic [3:0] set_sel,
    output logic [2:0] alu_op,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SETUP, SET, HOLD} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [3:0] SET_N   = 4'(SET_CYCLES);

    localparam logic [3:0] SEL_DATA = 4'd1;
    localparam logic [3:0] SEL_TMP  = 4'd6;
    localparam logic [3:0] SEL_ACC  = 4'd7;

    state_t     state;
    logic [1:0] step;
    logic [3:0] set_cnt;
    logic [1:0] op_q, src_q, dst_q;

    function automatic logic [3:0] reg_code(input logic [1:0] idx);
        return 4'd2 + {2'b00, idx};
    endfunction

    // Bus driver for a given transfer of a command
    function automatic logic [3:0] xfer_ena(input logic [1:0] op, input logic [1:0] src,
                                            input logic [1:0] dst, input logic [1:0] stp);
        logic [3:0] e;
        e = 4'd0;
        case (op)
            OP_LOAD: e = SEL_DATA;
            OP_MOVE: e = reg_code(src);
            OP_ALU: begin
                case (stp)
                    2'd0:    e = reg_code(src);
                    2'd1:    e = reg_code(dst);
                    default: e = SEL_ACC;
                endcase
            end
            default: e = 4'd0;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] xfer_set(input logic [1:0] op, input logic [1:0] dst,
                                            input logic [1:0] stp);
        logic [3:0] s;
        s = 4'd0;
        case (op)
            OP_LOAD, OP_MOVE: s = reg_code(dst);
            OP_ALU: begin
                case (stp)
                    2'd0:    s = SEL_TMP;
                    2'd1:    s = SEL_ACC;
                    default: s = reg_code(dst);
                endcase
            end
            default: s = 4'd0;
        endcase
        return s;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            step    <= 2'd0;
            set_cnt <= 4'd0;
            op_q    <= 2'd0;
            src_q   <= 2'd0;
            dst_q   <= 2'd0;
            ena_sel <= 4'd0;
            set_sel <= 4'd0;
            alu_op  <= 3'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ena_sel <= 4'd0;
                    set_sel <= 4'd0;
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        src_q <= cmd_src;
                        dst_q <= cmd_dst;
                        step  <= 2'd0;
                        if (cmd_op == OP_ALU)
                            alu_op <= cmd_alu;
                        // Reserved opcode completes immediately without leaving IDLE
                        if (cmd_op == 2'b11) begin
                            done <= 1'b1;
                        end else begin
                            state   <= SETUP;
                            ena_sel <= xfer_ena(cmd_op, cmd_src, cmd_dst, 2'd0);
                        end
                    end
                end
                SETUP: begin
                    state   <= SET;
                    set_cnt <= 4'd1;
                    set_sel <= xfer_set(op_q, dst_q, step);
                end
                SET: begin
                    if (set_cnt >= SET_N) begin
                        state   <= HOLD;
                        set_sel <= 4'd0;
                    end else begin
                        set_cnt <= set_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (op_q != OP_ALU || step == 2'd2) begin
                        state   <= IDLE;
                        ena_sel <= 4'd0;
                        done    <= 1'b1;
                    end else begin
                        state   <= SETUP;
                        step    <= step + 2'd1;
                        ena_sel <= xfer_ena(op_q, src_q, dst_q, step + 2'd1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    ena_sel <= 4'd0;
                    set_sel <= 4'd0;
                end
            endcase
        end
    end

endmodule
